// File: rtl/segway_pkg.sv
// Shared types for the segway_core rider-detect / steering-enable path.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT     = 2'b01,
        STEER_EN = 2'b10
    } steer_state_t;

endpackage

// File: rtl/en_steer_hyst_ld_cell_cmp.sv
// Load-cell arithmetic: sum/difference and the threshold flags used by the FSM.
module ld_cell_cmp #(
    parameter int LD_W   = 12,
    parameter int MIN_WT = 'h200,
    parameter int HYST   = 'h020
) (
    input  logic [LD_W-1:0]   lft_ld,
    input  logic [LD_W-1:0]   rght_ld,
    output logic signed [LD_W:0] ld_cell_diff,
    output logic              sum_gt_min,
    output logic              sum_lt_min,
    output logic              diff_gt_1_4,
    output logic              diff_gt_15_16
);

    localparam logic [LD_W:0] ON_TH  = (LD_W+1)'(MIN_WT + HYST);
    localparam logic [LD_W:0] OFF_TH = (LD_W+1)'(MIN_WT - HYST);
    localparam logic [LD_W:0] ONE    = (LD_W+1)'(1);

    logic [LD_W:0] w_sum;
    logic [LD_W:0] w_diff;
    logic [LD_W:0] w_abs;

    // One extra bit keeps both the sum and the signed difference exact.
    assign w_sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign w_diff = {1'b0, lft_ld} - {1'b0, rght_ld};
    assign w_abs  = w_diff[LD_W] ? (~w_diff) + ONE : w_diff;

    assign ld_cell_diff  = $signed(w_diff);
    assign sum_gt_min    = w_sum > ON_TH;
    assign sum_lt_min    = w_sum < OFF_TH;
    assign diff_gt_1_4   = w_abs > (w_sum >> 2);
    assign diff_gt_15_16 = w_abs > (w_sum - (w_sum >> 4));

endmodule

// File: rtl/en_steer_hyst.sv
// Rider detect with weight hysteresis, settle timer and debounced rider loss.
module en_steer_hyst #(
    parameter int LD_W       = 12,
    parameter int MIN_WT     = 'h200,
    parameter int HYST       = 'h020,
    parameter int TMR_W      = 26,
    parameter int FAST_TMR_W = 15,
    parameter bit FAST_SIM   = 1'b0,
    parameter int OFF_CNT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LD_W-1:0]      lft_ld,
    input  logic [LD_W-1:0]      rght_ld,
    output logic                 en_steer,
    output logic                 rider_off,
    output logic signed [LD_W:0] ld_cell_diff
);

    import segway_pkg::*;

    localparam int TW   = FAST_SIM ? FAST_TMR_W : TMR_W;
    localparam int OC_W = (OFF_CNT > 1) ? $clog2(OFF_CNT) : 1;
    localparam logic [OC_W-1:0] OFF_LAST = OC_W'(OFF_CNT - 1);

    steer_state_t    r_state;
    steer_state_t    w_nxt;
    logic [TW-1:0]   r_tmr;
    logic [OC_W-1:0] r_off_cnt;

    logic w_gt_min;
    logic w_lt_min;
    logic w_diff_1_4;
    logic w_diff_15_16;
    logic w_tmr_full;
    logic w_off_exp;
    logic w_clr_tmr;

    ld_cell_cmp #(
        .LD_W   (LD_W),
        .MIN_WT (MIN_WT),
        .HYST   (HYST)
    ) u_cmp (
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .ld_cell_diff  (ld_cell_diff),
        .sum_gt_min    (w_gt_min),
        .sum_lt_min    (w_lt_min),
        .diff_gt_1_4   (w_diff_1_4),
        .diff_gt_15_16 (w_diff_15_16)
    );

    assign w_tmr_full = &r_tmr;
    assign w_off_exp  = (r_state != IDLE) && w_lt_min &&
                        (r_off_cnt == OFF_LAST);

    always_comb begin
        w_nxt     = r_state;
        w_clr_tmr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gt_min) begin
                    w_nxt     = WAIT;
                    w_clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (w_off_exp) begin
                    w_nxt = IDLE;
                end else if (w_diff_1_4) begin
                    w_clr_tmr = 1'b1;
                end else if (w_tmr_full) begin
                    w_nxt = STEER_EN;
                end
            end
            STEER_EN: begin
                if (w_off_exp) begin
                    w_nxt = IDLE;
                end else if (w_diff_15_16) begin
                    w_nxt     = WAIT;
                    w_clr_tmr = 1'b1;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Off counter restarts on any good-weight cycle and after it fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_off_cnt <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_tmr     <= w_clr_tmr ? '0 : r_tmr + TW'(1);
            if ((r_state == IDLE) || !w_lt_min || w_off_exp) begin
                r_off_cnt <= '0;
            end else begin
                r_off_cnt <= r_off_cnt + OC_W'(1);
            end
            en_steer  <= (w_nxt == STEER_EN);
            rider_off <= w_off_exp;
        end
    end

endmodule

// File: tb/tb_en_steer_hyst.sv
// Randomised bench for en_steer_hyst against a cycle-level behavioural model.
module tb_en_steer_hyst;

    localparam int LD_W    = 12;
    localparam int MIN_WT  = 'h200;
    localparam int HYST    = 'h020;
    localparam int FTW     = 8;
    localparam int OFF_CNT = 4;
    localparam int SETTLE  = 1 << FTW;
    localparam int ON_TH   = MIN_WT + HYST;
    localparam int OFF_TH  = MIN_WT - HYST;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [LD_W-1:0]      lft = '0;
    logic [LD_W-1:0]      rght = '0;
    logic                 en_steer;
    logic                 rider_off;
    logic signed [LD_W:0] ld_cell_diff;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = no rider, 1 = settling, 2 = steering.
    int m_st    = 0;
    int m_since = 0;
    int m_low   = 0;
    int exp_en  = 0;
    int exp_ro  = 0;

    en_steer_hyst #(
        .LD_W       (LD_W),
        .MIN_WT     (MIN_WT),
        .HYST       (HYST),
        .TMR_W      (26),
        .FAST_TMR_W (FTW),
        .FAST_SIM   (1'b1),
        .OFF_CNT    (OFF_CNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lft_ld       (lft),
        .rght_ld      (rght),
        .en_steer     (en_steer),
        .rider_off    (rider_off),
        .ld_cell_diff (ld_cell_diff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_since = 0;
        m_low   = 0;
        exp_en  = 0;
        exp_ro  = 0;
    endtask

    task automatic model_edge();
        int s, d, ad, nst;
        bit on, low, expire, settled, clr;
        s       = int'(lft) + int'(rght);
        d       = int'(lft) - int'(rght);
        ad      = (d < 0) ? -d : d;
        on      = s > ON_TH;
        low     = s < OFF_TH;
        expire  = (m_st != 0) && low && (m_low == OFF_CNT - 1);
        settled = (m_since % SETTLE) == SETTLE - 1;
        clr     = 1'b0;
        nst     = m_st;
        if (m_st == 0) begin
            if (on) begin
                nst = 1;
                clr = 1'b1;
            end
        end else if (expire) begin
            nst = 0;
        end else if (m_st == 1) begin
            if (ad > s / 4) clr = 1'b1;
            else if (settled) nst = 2;
        end else begin
            if (ad > s - s / 16) begin
                nst = 1;
                clr = 1'b1;
            end
        end
        m_since = clr ? 0 : m_since + 1;
        m_low   = (m_st != 0 && low && !expire) ? m_low + 1 : 0;
        exp_en  = (nst == 2) ? 1 : 0;
        exp_ro  = expire ? 1 : 0;
        m_st    = nst;
    endtask

    task automatic compare();
        chk("en_steer", int'(en_steer), exp_en);
        chk("rider_off", int'(rider_off), exp_ro);
        chk("ld_cell_diff", int'(ld_cell_diff),
            int'(lft) - int'(rght));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ld(input int l, input int r);
        lft  = LD_W'(l);
        rght = LD_W'(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_en_async", int'(en_steer), 0);
        chk("rst_ro_async", int'(rider_off), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        set_ld(0, 0);
        repeat (2) @(negedge clk);
        chk("reset_en", int'(en_steer), 0);
        chk("reset_ro", int'(rider_off), 0);
        rst = 1'b0;
        model_reset();

        // Mount: WAIT on first edge, steering SETTLE edges later.
        set_ld('h120, 'h120);
        step();
        chk("t1_diff_zero", int'(ld_cell_diff), 0);
        steps(SETTLE - 1);
        chk("t1_en_early", int'(en_steer), 0);
        chk("t1_model_early", exp_en, 0);
        step();
        chk("t1_en_rise", int'(en_steer), 1);
        chk("t1_model_rise", exp_en, 1);

        // In-band weight while steering keeps steering.
        set_ld('h100, 'h100);
        steps(20);
        chk("t2_band_en", int'(en_steer), 1);

        // Step-off imbalance drops back to settling.
        set_ld('h3F0, 'h0);
        step();
        chk("t4_en_drop", int'(en_steer), 0);
        chk("t4_no_ro", int'(rider_off), 0);

        // Resettle from WAIT, then debounce rider loss.
        set_ld('h120, 'h120);
        steps(SETTLE - 1);
        chk("t5_en_early", int'(en_steer), 0);
        step();
        chk("t5_en_rise", int'(en_steer), 1);
        set_ld('h80, 'h80);
        steps(3);
        chk("t5_dip_en", int'(en_steer), 1);
        set_ld('h120, 'h120);
        step();
        set_ld('h80, 'h80);
        steps(3);
        chk("t5_hold3_ro", int'(rider_off), 0);
        step();
        chk("t5_off_en", int'(en_steer), 0);
        chk("t5_off_ro", int'(rider_off), 1);
        chk("t5_model_ro", exp_ro, 1);
        step();
        chk("t5_ro_pulse", int'(rider_off), 0);

        // In-band weight from IDLE does not mount.
        set_ld('h100, 'h100);
        steps(20);
        chk("t2_idle_band", int'(en_steer), 0);

        // Unbalanced rider never settles until balanced.
        set_ld('h200, 'h40);
        steps(300);
        chk("t3_unbal_en", int'(en_steer), 0);
        set_ld('h120, 'h120);
        steps(SETTLE - 1);
        chk("t3_en_early", int'(en_steer), 0);
        step();
        chk("t3_en_rise", int'(en_steer), 1);

        do_reset();
        step();
        chk("t6_idle_after", int'(en_steer), 0);

        for (int sg = 0; sg < 150; sg++) begin
            int kind, len;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: len = int'($urandom_range(50, 400));
                4:          len = int'($urandom_range(5, 50));
                5:          len = int'($urandom_range(1, 6));
                6:          len = int'($urandom_range(10, 100));
                7:          len = int'($urandom_range(1, 10));
                default:    len = int'($urandom_range(1, 20));
            endcase
            if (kind == 9) begin
                do_reset();
            end else begin
                for (int c = 0; c < len; c++) begin
                    int b;
                    case (kind)
                        0, 1, 2, 3: begin
                            b = int'($urandom_range('h118, 'h1F0));
                            set_ld(b + int'($urandom_range(0, 15)),
                                   b + int'($urandom_range(0, 15)));
                        end
                        4: set_ld(int'($urandom_range('hF0, 'h110)),
                                  int'($urandom_range('hF0, 'h110)));
                        5: set_ld(int'($urandom_range(0, 'hEF)),
                                  int'($urandom_range(0, 'hEF)));
                        6: set_ld('h200, int'($urandom_range(0, 'h80)));
                        7: set_ld(int'($urandom_range('h300, 'hFFF)), 0);
                        default: set_ld(int'($urandom_range(0, 'hFFF)),
                                        int'($urandom_range(0, 'hFFF)));
                    endcase
                    step();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
